// File: rtl/max_unpool_if.sv
// max_unpool_if: valid/ready stream carrying one pixel for N_MAPS feature maps.
//   valid    : producer has a pixel on features
//   ready    : consumer accepts the pixel when valid & ready
//   features : signed per-map values, features[0:N_MAPS-1]
//   argmax   : 2-bit per-map position code (MAX_UNPOOL_ARGMAX_EN builds only)
// Modports: master = producer side, slave = consumer side.
interface max_unpool_if #(
  parameter int DW     = 8,
  parameter int N_MAPS = 6
);
  logic                 valid;
  logic                 ready;
  logic signed [DW-1:0] features [0:N_MAPS-1];
`ifdef MAX_UNPOOL_ARGMAX_EN
  logic [1:0]           argmax   [0:N_MAPS-1];

  modport master (output valid, output features, output argmax, input ready);
  modport slave  (input valid, input features, input argmax, output ready);
`else
  modport master (output valid, output features, input ready);
  modport slave  (input valid, input features, output ready);
`endif
endinterface

// File: rtl/max_unpool.sv
// max_unpool: 2x2 / stride-2 unpooling of N_MAPS pooled maps streamed in raster
// order. Each IN_H x IN_W map becomes 2*IN_H x 2*IN_W, also in raster order.
// Even output rows are produced straight from the input (each value twice) while
// the row is saved in a line buffer; odd output rows are replayed from that buffer.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   up (slave)    : pooled input stream
//   dn (master)   : unpooled output stream, features registered
//   o_frame_done  : 1-cycle pulse on the transfer of the last pixel of a frame
// Build option MAX_UNPOOL_ARGMAX_EN: up carries per-map argmax codes
// (0=TL 1=TR 2=BL 3=BR); only the matching pixel of each 2x2 window keeps the
// value, the other three are 0. Timing is the same in both builds.
//
// state | meaning
// S_TOP | even output row: accept input, emit left copy then right copy
// S_BOT | odd output row: replay line buffer, input stalled
module max_unpool #(
  parameter int IN_W   = 14,
  parameter int IN_H   = 14,
  parameter int N_MAPS = 6,
  parameter int DW     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  max_unpool_if.slave  up,
  max_unpool_if.master dn,
  output logic         o_frame_done
);
  localparam int OUT_W = 2 * IN_W;
  localparam int CW    = $clog2(IN_W);
  localparam int OCW   = $clog2(OUT_W);
  localparam int RW    = $clog2(IN_H);

  typedef enum logic {S_TOP, S_BOT} state_t;

  state_t               state, state_nxt;
  logic                 dup, dup_nxt;
  logic [CW-1:0]        in_col, in_col_nxt;
  logic [OCW-1:0]       out_col, out_col_nxt;
  logic [RW-1:0]        row, row_nxt;
  logic                 last_pix, last_pix_nxt;
  logic                 valid_nxt;
  logic                 slot_free;
  logic                 take_in;
  logic signed [DW-1:0] pix_nxt [0:N_MAPS-1];
  logic signed [DW-1:0] lbuf    [0:IN_W-1][0:N_MAPS-1];
`ifdef MAX_UNPOOL_ARGMAX_EN
  logic [1:0]           lcode   [0:IN_W-1][0:N_MAPS-1];

  always_comb begin
    for (int m = 0; m < N_MAPS; m++) dn.argmax[m] = 2'b00;
  end
`endif

  // last_pix marks that the output register holds the final pixel of the frame;
  // the pulse is tied to its actual downstream transfer.
  assign o_frame_done = last_pix & dn.valid & dn.ready;

  always_comb begin
    slot_free    = !dn.valid | dn.ready;
    up.ready     = (state == S_TOP) & !dup & slot_free;
    take_in      = up.valid & up.ready;
    state_nxt    = state;
    dup_nxt      = dup;
    in_col_nxt   = in_col;
    out_col_nxt  = out_col;
    row_nxt      = row;
    last_pix_nxt = last_pix;
    valid_nxt    = dn.valid;
    for (int m = 0; m < N_MAPS; m++) pix_nxt[m] = dn.features[m];

    if (slot_free) begin
      last_pix_nxt = 1'b0;
      case (state)
        S_TOP: begin
          if (!dup) begin
            if (up.valid) begin
              valid_nxt = 1'b1;
              dup_nxt   = 1'b1;
              for (int m = 0; m < N_MAPS; m++) begin
`ifdef MAX_UNPOOL_ARGMAX_EN
                pix_nxt[m] = (up.argmax[m] == 2'b00) ? up.features[m] : '0;
`else
                pix_nxt[m] = up.features[m];
`endif
              end
            end else begin
              valid_nxt = 1'b0;
            end
          end else begin
            // right copy comes from the line-buffer entry written on accept
            valid_nxt = 1'b1;
            dup_nxt   = 1'b0;
            for (int m = 0; m < N_MAPS; m++) begin
`ifdef MAX_UNPOOL_ARGMAX_EN
              pix_nxt[m] = (lcode[in_col][m] == 2'b01) ? lbuf[in_col][m] : '0;
`else
              pix_nxt[m] = lbuf[in_col][m];
`endif
            end
            if (in_col == CW'(IN_W - 1)) begin
              in_col_nxt = '0;
              state_nxt  = S_BOT;
            end else begin
              in_col_nxt = in_col + 1'b1;
            end
          end
        end
        S_BOT: begin
          valid_nxt = 1'b1;
          for (int m = 0; m < N_MAPS; m++) begin
`ifdef MAX_UNPOOL_ARGMAX_EN
            pix_nxt[m] = (lcode[out_col[OCW-1:1]][m] == {1'b1, out_col[0]}) ?
                         lbuf[out_col[OCW-1:1]][m] : '0;
`else
            pix_nxt[m] = lbuf[out_col[OCW-1:1]][m];
`endif
          end
          if (out_col == OCW'(OUT_W - 1)) begin
            out_col_nxt = '0;
            state_nxt   = S_TOP;
            if (row == RW'(IN_H - 1)) begin
              row_nxt      = '0;
              last_pix_nxt = 1'b1;
            end else begin
              row_nxt = row + 1'b1;
            end
          end else begin
            out_col_nxt = out_col + 1'b1;
          end
        end
        default: state_nxt = S_TOP;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_TOP;
      dup      <= 1'b0;
      in_col   <= '0;
      out_col  <= '0;
      row      <= '0;
      last_pix <= 1'b0;
      dn.valid <= 1'b0;
      for (int m = 0; m < N_MAPS; m++) dn.features[m] <= '0;
    end else begin
      state    <= state_nxt;
      dup      <= dup_nxt;
      in_col   <= in_col_nxt;
      out_col  <= out_col_nxt;
      row      <= row_nxt;
      last_pix <= last_pix_nxt;
      dn.valid <= valid_nxt;
      for (int m = 0; m < N_MAPS; m++) dn.features[m] <= pix_nxt[m];
    end
  end

  // line buffer needs no reset: every entry is written before it is read
  always_ff @(posedge i_clk) begin
    if (take_in) begin
      for (int m = 0; m < N_MAPS; m++) begin
        lbuf[in_col][m] <= up.features[m];
`ifdef MAX_UNPOOL_ARGMAX_EN
        lcode[in_col][m] <= up.argmax[m];
`endif
      end
    end
  end
endmodule
